// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-style memory responder.
package avl_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DATA  = 2'd3
    } avl_state_e;

    // Burst length field width and type
    localparam int unsigned LEN_W = 3;
    typedef logic [LEN_W-1:0] beat_len_t;

    // Protocol-violation causes, one bit each in err_cause_t
    localparam int unsigned ERR_CAUSES         = 4;
    localparam int unsigned ERR_RW_BOTH        = 0;
    localparam int unsigned ERR_NO_BEGIN       = 1;
    localparam int unsigned ERR_BEGIN_IN_BURST = 2;
    localparam int unsigned ERR_NOT_READY      = 3;
    typedef logic [ERR_CAUSES-1:0] err_cause_t;

    // A burst size of zero still carries one beat
    function automatic beat_len_t eff_len(input beat_len_t size);
        return (size == '0) ? beat_len_t'(1) : size;
    endfunction

endpackage

// File: rtl/avl_mem_responder_if.sv
// Command/data bus between an Avalon-style master and the memory responder.
interface avl_mem_responder_if
    import avl_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic                    avl_ready;
    logic [ADDR_WIDTH-1:0]   avl_addr;
    beat_len_t               avl_size;
    logic [LINE_WIDTH-1:0]   avl_wdata;
    logic [LINE_WIDTH/8-1:0] avl_be;
    logic                    avl_write_req;
    logic                    avl_read_req;
    logic                    avl_burstbegin;
    logic [LINE_WIDTH-1:0]   avl_rdata;
    logic                    avl_rdata_valid;

    modport master (
        input  avl_ready, avl_rdata, avl_rdata_valid,
        output avl_addr, avl_size, avl_wdata, avl_be,
               avl_write_req, avl_read_req, avl_burstbegin
    );

    modport slave (
        output avl_ready, avl_rdata, avl_rdata_valid,
        input  avl_addr, avl_size, avl_wdata, avl_be,
               avl_write_req, avl_read_req, avl_burstbegin
    );

endinterface

// File: rtl/avl_be_ram.sv
// Single-port-write, single-port-read RAM with byte enables and registered read data.
module avl_be_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_BITS = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    be,
    input  logic                  re,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-masked write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Synchronous read port
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-style burst memory responder: byte-masked write bursts, fixed-latency read bursts,
// sticky protocol-violation flag.
module avl_mem_responder
    import avl_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH_BITS   = 6,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    avl_mem_responder_if.slave avl,
    output logic               proto_err
);

    localparam int unsigned BYTES      = LINE_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned IDX_W      = DEPTH_BITS;
    localparam int unsigned LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    // Beat k is fetched from RAM one cycle before it is registered onto avl_rdata
    localparam int unsigned LAT_ISSUE  = READ_LATENCY - 2;
    localparam int unsigned LAT_LAST   = READ_LATENCY - 1;

    avl_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    beat_len_t             len_q, len_d;
    beat_len_t             beat_q, beat_d;
    beat_len_t             rd_left_q, rd_left_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  proto_err_d;

    logic [ADDR_WIDTH-1:0] addr_c;
    logic [IDX_W-1:0]      req_idx_c;
    logic [IDX_W-1:0]      ram_waddr_c;
    logic                  ram_we_c;
    logic                  rd_issue_c;
    logic [LINE_WIDTH-1:0] ram_q;
    err_cause_t            err_c;

    assign addr_c    = avl.avl_addr;
    assign req_idx_c = IDX_W'(addr_c >> BYTE_SHIFT);

    assign avl.avl_ready       = ready_q;
    assign avl.avl_rdata_valid = rvalid_q;
    assign avl.avl_rdata       = rdata_q;

    avl_be_ram #(
        .WIDTH      (LINE_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (avl.avl_wdata),
        .be    (avl.avl_be),
        .re    (rd_issue_c),
        .raddr (idx_q),
        .rdata (ram_q)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            rd_left_q <= '0;
            lat_q     <= '0;
            rd_pend_q <= 1'b0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            rd_left_q <= rd_left_d;
            lat_q     <= lat_d;
            rd_pend_q <= rd_pend_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            proto_err <= proto_err_d;
        end
    end

    // Next-state, RAM control and protocol checking
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        beat_d      = beat_q;
        rd_left_d   = rd_left_q;
        lat_d       = lat_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = idx_q;
        rd_issue_c  = 1'b0;
        err_c       = '0;

        // ready_q is low in the read states and in the first cycle out of reset
        if (!ready_q && (avl.avl_write_req || avl.avl_read_req)) begin
            err_c[ERR_NOT_READY] = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ready_q && (avl.avl_write_req || avl.avl_read_req)) begin
                    if (!avl.avl_burstbegin) begin
                        err_c[ERR_NO_BEGIN] = 1'b1;
                    end else if (avl.avl_write_req) begin
                        err_c[ERR_RW_BOTH] = avl.avl_read_req;
                        ram_we_c    = 1'b1;
                        ram_waddr_c = req_idx_c;
                        idx_d       = req_idx_c + IDX_W'(1);
                        len_d       = eff_len(avl.avl_size);
                        beat_d      = beat_len_t'(1);
                        if (eff_len(avl.avl_size) > beat_len_t'(1)) begin
                            state_d = ST_WR_BURST;
                        end
                    end else begin
                        idx_d     = req_idx_c;
                        len_d     = eff_len(avl.avl_size);
                        rd_left_d = eff_len(avl.avl_size);
                        beat_d    = '0;
                        lat_d     = '0;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_BURST: begin
                err_c[ERR_BEGIN_IN_BURST] = avl.avl_burstbegin;
                if (avl.avl_write_req) begin
                    ram_we_c = 1'b1;
                    idx_d    = idx_q + IDX_W'(1);
                    beat_d   = beat_q + beat_len_t'(1);
                    if (beat_q == len_q - beat_len_t'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                rd_issue_c = (rd_left_q != '0) && (lat_q >= LAT_W'(LAT_ISSUE));
                if (lat_q == LAT_W'(LAT_LAST)) begin
                    state_d = ST_RD_DATA;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_RD_DATA: begin
                rd_issue_c = (rd_left_q != '0);
                beat_d     = beat_q + beat_len_t'(1);
                if (beat_q == len_q - beat_len_t'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_issue_c) begin
            idx_d     = idx_q + IDX_W'(1);
            rd_left_d = rd_left_q - beat_len_t'(1);
        end

        rd_pend_d   = rd_issue_c;
        rvalid_d    = rd_pend_q;
        rdata_d     = rd_pend_q ? ram_q : '0;
        ready_d     = (state_d == ST_IDLE) || (state_d == ST_WR_BURST);
        proto_err_d = proto_err || (|err_c);
    end

endmodule
